// File: rtl/dpwm_generador_10b.sv
// Digital PWM: prescaled period counter compared against a soft-start duty that slews toward a clamped setpoint.
// Latency: setpoint to target 1 clk, duty updates only at period wrap, pwm_out registered; no backpressure.
module dpwm_generador_10b #(
  parameter int PRESC      = 50,
  parameter int PERIODO    = 1000,
  parameter int PASO_RAMPA = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] cant_corriente,
  output logic       pwm_out,
  output logic       inicio_periodo,
  output logic [9:0] duty_actual,
  output logic       rampa_activa
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESC - 1);
  localparam logic [9:0]  CNT_MAX   = 10'(PERIODO - 1);
  localparam logic [9:0]  FULL      = 10'(PERIODO);
  localparam logic [10:0] PASO      = 11'(PASO_RAMPA);

  logic [15:0] presc_q, presc_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  objetivo_q, objetivo_d;
  logic [9:0]  duty_q, duty_d;
  logic        pwm_q, pwm_d;
  logic        inicio_q, inicio_d;

  logic        tick, fin;
  logic [10:0] d_ext, obj_ext, diff, paso;

  always_comb begin
    tick       = enable && (presc_q == PRESC_MAX);
    fin        = tick && (cnt_q == CNT_MAX);

    objetivo_d = (cant_corriente > FULL) ? FULL : cant_corriente;

    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    cnt_d      = cnt_q;
    if (tick) begin
      cnt_d = fin ? 10'd0 : cnt_q + 10'd1;
    end

    // 11-bit slew arithmetic: step is the smaller of the ramp limit and the remaining distance
    d_ext   = {1'b0, duty_q};
    obj_ext = {1'b0, objetivo_q};
    diff    = (d_ext < obj_ext) ? (obj_ext - d_ext) : (d_ext - obj_ext);
    paso    = (diff < PASO) ? diff : PASO;

    duty_d = duty_q;
    if (fin) begin
      if (d_ext < obj_ext) begin
        duty_d = 10'(d_ext + paso);
      end else begin
        duty_d = 10'(d_ext - paso);
      end
    end

    pwm_d    = enable && (cnt_q < duty_q);
    inicio_d = fin;

    if (!enable) begin
      presc_d  = '0;
      cnt_d    = '0;
      duty_d   = '0;
      pwm_d    = 1'b0;
      inicio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      objetivo_q <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
      inicio_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      objetivo_q <= objetivo_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      inicio_q   <= inicio_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign inicio_periodo = inicio_q;
  assign duty_actual    = duty_q;
  assign rampa_activa   = (duty_q != objetivo_q);

endmodule

// File: tb/tb_dpwm_generador_10b.sv
// Directed bench for dpwm_generador_10b with PRESC=2, PERIODO=1000, PASO_RAMPA=100 (one period = 2000 clk).
module tb_dpwm_generador_10b;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] cant_corriente;
  logic       pwm_out;
  logic       inicio_periodo;
  logic [9:0] duty_actual;
  logic       rampa_activa;

  int n_tests = 0;
  int n_fail  = 0;

  dpwm_generador_10b #(
    .PRESC(2),
    .PERIODO(1000),
    .PASO_RAMPA(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .cant_corriente(cant_corriente),
    .pwm_out(pwm_out),
    .inicio_periodo(inicio_periodo),
    .duty_actual(duty_actual),
    .rampa_activa(rampa_activa)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Counts falling edges until the strobe is seen, then checks the interval.
  task automatic wait_strobe(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inicio_periodo && n < 2100);
    chk({tag, "_interval"}, n, exp_n);
  endtask

  task automatic measure(input int n, output int hi, output int st);
    hi = 0;
    st = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (pwm_out) hi++;
      if (inicio_periodo) st++;
    end
  endtask

  int hi, st, hi2, st2;
  int dn_seq[6] = '{405, 305, 205, 105, 5, 0};

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    cant_corriente = 10'd0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_inicio", inicio_periodo, 0);
    chk("rst_duty", duty_actual, 0);
    chk("rst_rampa", rampa_activa, 0);

    // Soft-start to 500
    reset = 1'b0;
    enable = 1'b1;
    cant_corriente = 10'd500;
    for (int i = 1; i <= 5; i++) begin
      wait_strobe($sformatf("ss%0d", i), 2000);
      chk($sformatf("ss%0d_duty", i), duty_actual, 100 * i);
    end
    chk("ss_rampa_done", rampa_activa, 0);
    measure(2000, hi, st);
    chk("ss_high_time", hi, 1000);
    chk("ss_one_strobe", st, 1);
    chk("ss_hold_duty", duty_actual, 500);

    // Setpoint change at cnt=300: this period keeps 500, next boundary steps down
    measure(600, hi, st);
    cant_corriente = 10'd200;
    measure(1400, hi2, st2);
    chk("mid_high_time", hi + hi2, 1000);
    chk("mid_strobe", inicio_periodo, 1);
    chk("mid_duty", duty_actual, 400);

    cant_corriente = 10'd500;
    wait_strobe("back500", 2000);
    chk("back500_duty", duty_actual, 500);

    // Fine step up, then ramp down to zero
    cant_corriente = 10'd505;
    wait_strobe("fine", 2000);
    chk("fine_duty", duty_actual, 505);
    chk("fine_rampa", rampa_activa, 0);
    cant_corriente = 10'd0;
    @(negedge clk);
    chk("dn_rampa_on", rampa_activa, 1);
    for (int i = 0; i < 6; i++) begin
      wait_strobe($sformatf("dn%0d", i), (i == 0) ? 1999 : 2000);
      chk($sformatf("dn%0d_duty", i), duty_actual, dn_seq[i]);
    end
    measure(2000, hi, st);
    chk("zero_high_time", hi, 0);
    chk("zero_rampa", rampa_activa, 0);

    // Clamp and full scale
    cant_corriente = 10'd1020;
    for (int i = 1; i <= 10; i++) begin
      wait_strobe($sformatf("up%0d", i), 2000);
      chk($sformatf("up%0d_duty", i), duty_actual, 100 * i);
    end
    chk("full_rampa", rampa_activa, 0);
    measure(2100, hi, st);
    chk("full_high_time", hi, 2100);
    chk("full_strobe", st, 1);

    // Enable drop at cnt=700
    measure(1300, hi, st);
    chk("pre_drop_pwm", pwm_out, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_pwm", pwm_out, 0);
    chk("drop_duty", duty_actual, 0);
    chk("drop_inicio", inicio_periodo, 0);
    chk("drop_rampa", rampa_activa, 1);
    repeat (4) @(negedge clk);
    chk("drop_hold_duty", duty_actual, 0);
    enable = 1'b1;
    wait_strobe("reen", 2000);
    chk("reen_duty", duty_actual, 100);

    // Reset mid-ramp at duty 300
    wait_strobe("r2", 2000);
    wait_strobe("r3", 2000);
    chk("r3_duty", duty_actual, 300);
    measure(500, hi, st);
    chk("pre_rst_pwm", pwm_out, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_pwm", pwm_out, 0);
    chk("mrst_inicio", inicio_periodo, 0);
    chk("mrst_duty", duty_actual, 0);
    chk("mrst_rampa", rampa_activa, 0);
    wait_strobe("restart", 2000);
    chk("restart_duty", duty_actual, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
